multdiv_sequencer: RTL
======================

// Module: multdiv_sequencer
// PURPOSE
//  Control stage directly upstream of the signed divider and the multiplier in the multdiv unit.
//  - Accepts one-cycle ctrl_MULT/ctrl_DIV pulses from the pipeline and latches the operands.
//  - Drives the selected unit's one-cycle start, then waits for its ready.
//  - Returns a registered result, exception flag and a one-cycle data_resultRDY pulse.
// PARAMETERS
//  WIDTH    32  operand/result width
//  TIMEOUT  40  max cycles in WAIT before the op is forced done with exception=1
// PORTS
//  clock           in   1      single clock, rising edge
//  reset           in   1      asynchronous, active-high
//  data_operandA   in   WIDTH  dividend / multiplicand, sampled on ctrl pulse
//  data_operandB   in   WIDTH  divisor / multiplier, sampled on ctrl pulse
//  ctrl_MULT       in   1      one-cycle request: multiply
//  ctrl_DIV        in   1      one-cycle request: divide
//  data_result     out  WIDTH  quotient or product, held until next completion
//  data_exception  out  1      div-by-zero, mult overflow or timeout; valid with RDY
//  data_resultRDY  out  1      one-cycle completion pulse
//  busy            out  1      high from cycle after ctrl pulse until RDY cycle
//  div_start       out  1      one-cycle start to divider
//  div_D, div_V    out  WIDTH  latched operands to divider (stable through WAIT)
//  div_quotient    in   WIDTH  divider result
//  div_ready       in   1      divider done (count==0); invalid in the start cycle
//  div_exception   in   1      divider divisor==0 flag
//  mult_start      out  1      one-cycle start to multiplier
//  mult_A, mult_B  out  WIDTH  latched operands to multiplier
//  mult_product    in   WIDTH  multiplier result (low word)
//  mult_ready      in   1      multiplier done
//  mult_overflow   in   1      product does not fit WIDTH signed
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; operand regs 0; timeout counter 0.
//  States: IDLE, LAUNCH, WAIT, DONE. op_is_div reg selects the unit.
//  IDLE: ctrl_DIV|ctrl_MULT -> latch A, B, op -> LAUNCH. Both high same cycle: DIV wins.
//  LAUNCH (1 cycle): assert div_start or mult_start only; clear timeout counter -> WAIT.
//  WAIT: the ready of the unit not selected by op is ignored. Selected unit's ready==1 ->
//   capture result+exception -> DONE. Counter reaches TIMEOUT ->
//   result=0, exception=1 -> DONE.
//  DONE (1 cycle): data_resultRDY=1, busy=0 -> IDLE. A ctrl pulse in DONE is accepted
//   (treated exactly as in IDLE).
//  Ready is never sampled in LAUNCH: the unit counters are stale until the first edge after start.
//  New ctrl pulse in LAUNCH/WAIT: abort current op, no RDY for it, re-latch operands,
//   -> LAUNCH. The abandoned unit is not stopped; its later ready is ignored via op.
//  Div exception: capture div_exception | (latched B==0); on exception data_result=0.
//  Mult exception: mult_overflow; data_result=mult_product regardless.
//  data_result/data_exception change only on the DONE entry edge. Between ops they hold.
//  Latency with divider (32-cycle count): ctrl in cycle 0 -> start in cycle 1 -> RDY in cycle 34.
//  Reset mid-op: immediate IDLE, starts low, RDY never pulses for the op.
// CONFIGURATION
//  MULTDIV_DIV0_SHORTCUT_EN defined: ctrl_DIV with operandB==0 skips LAUNCH/WAIT.
//   Goes IDLE -> DONE; div_start is never driven; result=0, exception=1, RDY in cycle 1.
//  Undefined: divide-by-zero runs the full divider sequence. It reports result=0,
//   exception=1 at the normal latency.
// TESTING
//  ctrl_DIV, A=100, B=7 -> div_start high only in cycle 1; RDY cycle 34; result=14, exc=0.
//  ctrl_DIV, A=-100 (0xFFFFFF9C), B=7 -> result=0xFFFFFFF2, exc=0.
//  ctrl_DIV, B=0 -> result=0, exc=1; RDY cycle 1 with SHORTCUT_EN, cycle 34 without.
//  ctrl_MULT, A=0x10000, B=0x10000, overflow model -> result=0, exc=1 at mult_ready+1.
//  ctrl_DIV 100/7, then ctrl_MULT 3*5 at cycle 10 -> exactly one RDY, result=15.
//  Stuck unit (ready never rises) -> RDY at cycle 2+TIMEOUT, exc=1, result=0.
//  Reset asserted mid-WAIT -> all outputs 0 asynchronously; no RDY after release.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// Sequences one multiply or divide request: latches the operands, launches the selected
// unit, waits for its ready (bounded by TIMEOUT) and returns a registered result.
// Optional MULTDIV_DIV0_SHORTCUT_EN: divide-by-zero completes without launching the divider.
module multdiv_sequencer #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 40
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy,
   output logic             div_start,
   output logic [WIDTH-1:0] div_D,
   output logic [WIDTH-1:0] div_V,
   input  logic [WIDTH-1:0] div_quotient,
   input  logic             div_ready,
   input  logic             div_exception,
   output logic             mult_start,
   output logic [WIDTH-1:0] mult_A,
   output logic [WIDTH-1:0] mult_B,
   input  logic [WIDTH-1:0] mult_product,
   input  logic             mult_ready,
   input  logic             mult_overflow
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

   state_t           state_q, state_d;
   logic             op_is_div_q, op_is_div_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             exc_q, exc_d;
   logic             rdy_q, rdy_d;
   logic             busy_q, busy_d;
   logic             div_start_q, div_start_d;
   logic             mult_start_q, mult_start_d;
   logic             div_bad_s;

   assign div_bad_s = div_exception || (b_q == {WIDTH{1'b0}});

   // A new request always wins over the op in flight, so an abort needs no extra state.
   always_comb begin
      state_d     = state_q;
      op_is_div_d = op_is_div_q;
      a_d         = a_q;
      b_d         = b_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      exc_d       = exc_q;
      if (ctrl_DIV || ctrl_MULT) begin
         op_is_div_d = ctrl_DIV;
         a_d         = data_operandA;
         b_d         = data_operandB;
`ifdef MULTDIV_DIV0_SHORTCUT_EN
         if (ctrl_DIV && (data_operandB == {WIDTH{1'b0}})) begin
            state_d  = DONE;
            result_d = {WIDTH{1'b0}};
            exc_d    = 1'b1;
         end else begin
            state_d = LAUNCH;
         end
`else
         state_d = LAUNCH;
`endif
      end else begin
         case (state_q)
            LAUNCH: begin
               state_d = WAIT;
               cnt_d   = {CW{1'b0}};
            end
            WAIT: begin
               if (op_is_div_q && div_ready) begin
                  state_d  = DONE;
                  result_d = div_bad_s ? {WIDTH{1'b0}} : div_quotient;
                  exc_d    = div_bad_s;
               end else if (!op_is_div_q && mult_ready) begin
                  state_d  = DONE;
                  result_d = mult_product;
                  exc_d    = mult_overflow;
               end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                  state_d  = DONE;
                  result_d = {WIDTH{1'b0}};
                  exc_d    = 1'b1;
               end else begin
                  cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            default: state_d = IDLE;
         endcase
      end
      rdy_d        = (state_d == DONE);
      busy_d       = (state_d == LAUNCH) || (state_d == WAIT);
      div_start_d  = (state_d == LAUNCH) && op_is_div_d;
      mult_start_d = (state_d == LAUNCH) && !op_is_div_d;
   end

   // State, operand latches and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         op_is_div_q  <= 1'b0;
         a_q          <= {WIDTH{1'b0}};
         b_q          <= {WIDTH{1'b0}};
         cnt_q        <= {CW{1'b0}};
         result_q     <= {WIDTH{1'b0}};
         exc_q        <= 1'b0;
         rdy_q        <= 1'b0;
         busy_q       <= 1'b0;
         div_start_q  <= 1'b0;
         mult_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_is_div_q  <= op_is_div_d;
         a_q          <= a_d;
         b_q          <= b_d;
         cnt_q        <= cnt_d;
         result_q     <= result_d;
         exc_q        <= exc_d;
         rdy_q        <= rdy_d;
         busy_q       <= busy_d;
         div_start_q  <= div_start_d;
         mult_start_q <= mult_start_d;
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = busy_q;
   assign div_start      = div_start_q;
   assign mult_start     = mult_start_q;
   assign div_D          = a_q;
   assign div_V          = b_q;
   assign mult_A         = a_q;
   assign mult_B         = b_q;

endmodule
